// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg: state encoding and hit-counter saturation helper for serial_stim_ctrl.
package fsm_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;
  localparam int CNT_W_DEF = 8;
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
  localparam int unsigned CNT_MAX = cnt_max(CNT_W_DEF);
endpackage

// File: rtl/rot_shreg.sv
// rot_shreg: WIDTH-bit load / rotate-left register, MSB is the serial output.
module rot_shreg #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             rot,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  always_comb
    shreg_d = load ? d : rot ? {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]} : shreg_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) shreg_q <= '0;
    else shreg_q <= shreg_d;
  assign msb = shreg_q[WIDTH-1];
endmodule

// File: rtl/serial_stim_ctrl.sv
// serial_stim_ctrl: rotates a test pattern into the sequence detector for N rounds
// and counts its z pulses, behind a start/busy/done handshake.
module serial_stim_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int RND_W = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [RND_W-1:0] rounds,
  input  logic             z_in,
  output logic             x_out,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] HIT_MAX = CNT_W'(cnt_max(CNT_W));
  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d, rnd_lim_q, rnd_lim_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, hit_next;
  logic             load, rot, last_bit, last_rnd;
  rot_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .rot  (rot),
    .d    (pat_in),
    .msb  (x_out)
  );
  assign last_bit = bit_cnt_q == BW'(WIDTH - 1);
  assign last_rnd = rnd_cnt_q == rnd_lim_q - RND_W'(1);
  assign hit_next = (z_in && hit_cnt_q != HIT_MAX) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rnd_cnt_d = rnd_cnt_q;
    rnd_lim_d = rnd_lim_q;
    hit_cnt_d = hit_cnt_q;
    load      = 1'b0;
    rot       = 1'b0;
    if (abort) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = start ? LOAD : IDLE;
        LOAD: begin
          load      = 1'b1;
          rnd_lim_d = (rounds == '0) ? RND_W'(1) : rounds;
          bit_cnt_d = '0;
          rnd_cnt_d = '0;
          hit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          rot       = 1'b1;
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
          rnd_cnt_d = last_bit ? rnd_cnt_q + RND_W'(1) : rnd_cnt_q;
          hit_cnt_d = hit_next;
          state_d   = (last_bit && last_rnd) ? DRAIN : SHIFT;
        end
        DRAIN: begin
          hit_cnt_d = hit_next;
          state_d   = DONE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rnd_cnt_q <= '0;
      rnd_lim_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rnd_cnt_q <= rnd_cnt_d;
      rnd_lim_q <= rnd_lim_d;
      hit_cnt_q <= hit_cnt_d;
    end
  assign det_rst = !(state_q == SHIFT || state_q == DRAIN);
  assign busy    = state_q == LOAD || state_q == SHIFT || state_q == DRAIN;
  assign done    = state_q == DONE;
  assign hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_serial_stim_ctrl.sv
// tb_serial_stim_ctrl: directed checks of sequencing, hit counting, handshake, abort and reset.
module tb_serial_stim_ctrl;
  localparam int W  = 25;
  localparam int RW = 4;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n, start, abort, z_in;
  logic [W-1:0]  pat_in;
  logic [RW-1:0] rounds;
  logic          x_out, det_rst, busy, done;
  logic [CW-1:0] hit_cnt;
  logic [W-1:0]  pat;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc, bc, dc;
  serial_stim_ctrl #(.WIDTH(W), .RND_W(RW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .start   (start),
    .abort   (abort),
    .pat_in  (pat_in),
    .rounds  (rounds),
    .z_in    (z_in),
    .x_out   (x_out),
    .det_rst (det_rst),
    .busy    (busy),
    .done    (done),
    .hit_cnt (hit_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // start must already be high; returns the cycle count at which done is seen
  task automatic run_to_done(output int c);
    c = 0;
    tick;
    start = 1'b0;
    c = 1;
    while (!done && c < 200) begin
      tick;
      c++;
    end
  endtask
  initial begin
    pat    = 25'b0010101101011100010101100;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    z_in   = 1'b0;
    pat_in = pat;
    rounds = 4'd1;
    #3;
    chk("rst_x_out", 32'(x_out), 0);
    chk("rst_det_rst", 32'(det_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit", 32'(hit_cnt), 0);
    #9 rst_n = 1'b1;
    tick;
    chk("idle_det_rst", 32'(det_rst), 1);
    // single round, pattern out MSB-first
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_det_rst", 32'(det_rst), 1);
    tick;
    chk("shift_det_rst", 32'(det_rst), 0);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("p1_x%0d", k), 32'(x_out), 32'(pat[W-1-k]));
      tick;
    end
    chk("p1_drain_busy", 32'(busy), 1);
    chk("p1_drain_det", 32'(det_rst), 0);
    chk("p1_drain_done", 32'(done), 0);
    tick;
    chk("p1_done", 32'(done), 1);
    chk("p1_done_busy", 32'(busy), 0);
    chk("p1_done_det", 32'(det_rst), 1);
    chk("p1_hit", 32'(hit_cnt), 0);
    tick;
    chk("p1_idle_done", 32'(done), 0);
    // two rounds, 7 SHIFT hits + 1 DRAIN hit
    rounds = 4'd2;
    start  = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int k = 0; k < 2 * W; k++) begin
      chk($sformatf("p2_x%0d", k), 32'(x_out), 32'(pat[W-1-(k%W)]));
      z_in = (k >= 3 && k < 10);
      tick;
    end
    chk("p2_drain_busy", 32'(busy), 1);
    chk("p2_drain_det", 32'(det_rst), 0);
    z_in = 1'b1;
    tick;
    z_in = 1'b0;
    chk("p2_done", 32'(done), 1);
    chk("p2_hit", 32'(hit_cnt), 8);
    tick;
    z_in = 1'b1;
    tick;
    tick;
    chk("p2_idle_hold", 32'(hit_cnt), 8);
    // rounds=0 runs once, counter saturates
    rounds = 4'd0;
    start  = 1'b1;
    run_to_done(cyc);
    chk("sat_done_cyc", 32'(cyc), 28);
    chk("sat_hit", 32'(hit_cnt), 15);
    tick;
    chk("sat_done_once", 32'(done), 0);
    z_in = 1'b0;
    // start during SHIFT and DONE is ignored
    rounds = 4'd1;
    start  = 1'b1;
    bc = 0;
    dc = 0;
    for (int c = 1; c <= 45; c++) begin
      tick;
      start = 1'b0;
      bc += int'(busy);
      dc += int'(done);
      if (c == 7 || done) start = 1'b1;
    end
    start = 1'b0;
    chk("hs_busy_cycles", 32'(bc), 27);
    chk("hs_done_count", 32'(dc), 1);
    // abort at SHIFT cycle 10 with 3 hits
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int k = 0; k < 10; k++) begin
      z_in = (k == 2 || k == 4 || k == 6);
      tick;
    end
    chk("ab_hits_before", 32'(hit_cnt), 3);
    z_in  = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    z_in  = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_det_rst", 32'(det_rst), 1);
    chk("ab_hit", 32'(hit_cnt), 3);
    chk("ab_done", 32'(done), 0);
    dc = 0;
    repeat (30) begin
      tick;
      dc += int'(done);
    end
    chk("ab_no_done", 32'(dc), 0);
    chk("ab_hit_held", 32'(hit_cnt), 3);
    start = 1'b1;
    run_to_done(cyc);
    chk("ab_rerun_cyc", 32'(cyc), 28);
    chk("ab_rerun_hit", 32'(hit_cnt), 0);
    tick;
    // async reset mid-SHIFT
    z_in  = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("ar_hit_pre", 32'(hit_cnt), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_det_rst", 32'(det_rst), 1);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_hit", 32'(hit_cnt), 0);
    chk("ar_x_out", 32'(x_out), 0);
    chk("ar_done", 32'(done), 0);
    #2 rst_n = 1'b1;
    z_in = 1'b0;
    bc = 0;
    repeat (5) begin
      tick;
      bc += int'(busy);
    end
    chk("ar_stays_idle", 32'(bc), 0);
    start = 1'b1;
    run_to_done(cyc);
    chk("ar_rerun_cyc", 32'(cyc), 28);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_stim_ctrl.md
Name: serial_stim_ctrl

Overview:
Controller that sequences the serial sequence-detector FSM datapath. It loads a parallel test pattern and holds the detector in reset while idle. It then rotates the pattern out MSB-first, one bit per clock, on the detector's x input for a programmable number of rounds, and counts the detector's z pulses. It replaces free-running bench shift logic with a start/busy/done handshake that other blocks or a bench can drive.

Parameters:
WIDTH, 25, pattern length in bits (>= 2)
RND_W, 4, width of rounds field
CNT_W, 8, width of hit counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle request; honoured only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state
pat_in  input  WIDTH  pattern, sampled in LOAD
rounds  input  RND_W  pattern repetitions, sampled in LOAD; 0 treated as 1
z_in  input  1  detector output z
x_out  output  1  serial bit to detector x; equals shreg[WIDTH-1]
det_rst  output  1  active-high reset to detector
busy  output  1  high in LOAD, SHIFT, DRAIN
done  output  1  one-cycle pulse in DONE
hit_cnt  output  CNT_W  z pulses counted in the last run; saturating

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, bit_cnt=0, rnd_cnt=0, hit_cnt=0. Outputs: x_out=0, det_rst=1, busy=0, done=0.
- States: IDLE, LOAD, SHIFT, DRAIN, DONE. Encoding is fixed in the package.
- IDLE:
  - det_rst=1.
  - start=1 -> LOAD.
  - hit_cnt holds its last value.
- LOAD (1 cycle):
  - shreg<=pat_in; rnd_lim<=(rounds==0 ? 1 : rounds).
  - bit_cnt<=0; rnd_cnt<=0; hit_cnt<=0.
  - det_rst=1.
  - -> SHIFT.
- SHIFT:
  - det_rst=0.
  - Each cycle: shreg<=rotate-left by 1; bit_cnt++.
  - When bit_cnt==WIDTH-1: bit_cnt<=0 and rnd_cnt++.
  - If that was the last round (rnd_cnt==rnd_lim-1) -> DRAIN.
  - Exactly WIDTH*rnd_lim cycles in SHIFT.
  - x_out during SHIFT cycle k is pat_in[WIDTH-1-(k mod WIDTH)].
- DRAIN (1 cycle):
  - det_rst=0.
  - Catches z for the final bit; x_out shows the rotated pattern's MSB (don't-care to the detector).
  - -> DONE.
- DONE (1 cycle): done=1, det_rst=1, busy=0; -> IDLE.
- Hit counting: in SHIFT and DRAIN, if z_in==1 then hit_cnt++ each cycle, saturating at 2^CNT_W-1. No counting in any other state.
- Timing: start sampled at edge 0 -> LOAD after edge 0; first bit on x_out after edge 1; done high in the cycle after edge WIDTH*rnd_lim+2; back in IDLE after edge WIDTH*rnd_lim+3.
- Handshake:
  - start is ignored while busy or in DONE.
  - start coincident with DONE is dropped; the requester waits for busy=0 && done=0.
- abort=1:
  - Next state is IDLE from any state; det_rst=1 the following cycle.
  - hit_cnt frozen; no done pulse.
  - abort has priority over start.
- rst asserted mid-run: immediate return to reset values. Run is lost; no done.

Decomposition:
- Package fsm_ctrl_pkg holds:
  - the state typedef/localparams (IDLE=0, LOAD=1, SHIFT=2, DRAIN=3, DONE=4, 3-bit)
  - the saturation helper constant CNT_MAX.
- One natural sub-module, rot_shreg: a WIDTH-bit load/rotate-left register with serial MSB out. Counters and FSM stay in the top.

Test Plan:
- Pattern check: WIDTH=25, pat_in=25'b0010101101011100010101100, rounds=1, z_in=0 -> x_out sequence over 25 SHIFT cycles equals pat_in MSB-first; done pulses at cycle 28 after start; hit_cnt=0.
- Hit count: same pattern, rounds=2, stub z_in=1 for 7 SHIFT cycles plus 1 in DRAIN -> 50 SHIFT cycles; done at cycle 53; hit_cnt=8.
- Saturation and rounds=0: CNT_W=4, z_in tied 1, rounds=0 -> one round run (25 SHIFT cycles); hit_cnt=15; done once.
- Handshake: pulse start at cycle 5 of SHIFT and in the DONE cycle -> both ignored; busy stays high for exactly 27 cycles; a single done.
- Abort: abort=1 at SHIFT cycle 10 with 3 hits counted -> IDLE next cycle; det_rst=1; hit_cnt=3 held; no done; a new start then runs normally.
- Async reset: drive rst=0 mid-SHIFT between clock edges -> outputs go to reset values immediately (det_rst=1, busy=0, hit_cnt=0); after rst=1 the block stays in IDLE until start.
